video_bar_ctrl: RTL and testbench
=================================

# video_bar_ctrl

Frame-synchronous controller for the bar pattern generator. It holds software-written control registers and commits them only at frame start, so a pattern never changes mid-frame. It can auto-cycle the pattern mode every N frames. It drives the generator's band select and muxes generator RGB against the upstream video stream with one registered stage. It sits between the register bus and the bar generator inside the bar video core, fed by the shared `hc`/`vc` counters and the sync core's frame-start pulse.

## Interface
Parameters:
- `FRAME_CNT_W`, default 8: width of the period register and frame counter.
- `DEFAULT_MODE`, default 0: mode loaded at reset.

Ports:
- `clk`  in  1: system/pixel clock.
- `rst`  in  1: reset, synchronous, active-high.
- `wr_en`  in  1: register write strobe, single cycle.
- `wr_addr`  in  1: 0 = CTRL, 1 = PERIOD.
- `wr_data`  in  32: write data.
- `frame_start`  in  1: one-cycle pulse at `hc`=0, `vc`=0.
- `hc`  in  `H_SIZE`: horizontal pixel counter.
- `vc`  in  `V_SIZE`: vertical pixel counter.
- `gen_rgb`  in  12: bar generator output.
- `in_rgb`  in  12: upstream video.
- `band_sel`  out  2: band selector to generator; 0 gray, 1 primary, 2 rainbow.
- `out_rgb`  out  12: registered output pixel.
- `cur_mode`  out  2: committed mode.
- `bar_en`  out  1: committed enable.

## Operation
- CTRL layout: bit0 enable, bit1 auto, bits[3:2] mode. Other bits are ignored.
- PERIOD layout: bits[FRAME_CNT_W-1:0] frames per pattern in auto. A value of 0 behaves as 1.
- Writes update shadow registers only.
- Commit occurs on the `frame_start` cycle:
  - shadow is copied to active;
  - if CTRL was written since the last commit, the frame counter clears to 0 and no auto-advance happens that frame.
- Auto-advance applies when active auto=1 and no pending CTRL write. On each `frame_start`:
  - if counter == effective_period-1, the mode advances 0→1→2→3→0 and the counter goes to 0;
  - otherwise the counter increments.
  - The advanced mode is also written back to shadow mode, so a later PERIOD-only write does not revert it.
- With auto=0 the frame counter holds at 0.
- Modes and `band_sel`:
  - 0: three bands. `vc` < `V_DISPLAY`/3 → 0; `vc` < (`V_DISPLAY`/3)*2 → 1; else 2.
  - 1: full-screen gray, 0.
  - 2: full-screen primary, 1.
  - 3: full-screen rainbow, 2.
- `band_sel` is combinational from the active mode and `vc`, matching the generator's combinational path.
- RGB mux: `out_rgb` is registered. It takes `gen_rgb` when active enable=1, otherwise `in_rgb`.

## Timing
- Reset values:
  - shadow/active enable = 0, auto = 0, mode = `DEFAULT_MODE`;
  - PERIOD = 60; frame counter = 0; pending flag = 0;
  - `out_rgb` = 0, `bar_en` = 0, `cur_mode` = `DEFAULT_MODE`.
- Write → visible: the new value appears on `cur_mode`/`bar_en` the cycle after the next `frame_start`, never earlier.
- A write in the same cycle as `frame_start` is not committed by that pulse. It lands in shadow, sets pending, and commits at the following `frame_start`.
- Several writes between frames: the last one wins.
- `out_rgb` latency: 1 cycle from `gen_rgb`/`in_rgb`/enable. Downstream sync signals must be delayed 1 cycle to match.
- Enable change takes effect on `out_rgb` at the first pixel of the new frame, i.e. the cycle after `frame_start` plus 1-cycle latency.
- Reset mid-frame: all state returns to reset values in the next cycle, and no commit is pending.
- A PERIOD reduced below the current count takes effect at commit. If counter ≥ new effective_period-1, the next `frame_start` advances the mode.

## Test plan
- Reset, no writes; drive `hc`/`vc` over a frame → `bar_en`=0, `out_rgb`==`in_rgb` delayed 1 cycle, `cur_mode`=0, `band_sel` 0/1/2 at `vc`=0/160/320 (640x480).
- Write CTRL=0x1 mid-frame → `bar_en` stays 0 until after the next `frame_start`; then `out_rgb`==`gen_rgb` delayed 1 cycle.
- Write CTRL=0xD (enable, mode 3) in the same cycle as `frame_start` → not committed by that pulse; `cur_mode`=3 after the following `frame_start`; `band_sel`=2 for all `vc`.
- PERIOD=2, CTRL=0x3 → after commit, the mode sequence per frame is 0,0,1,1,2,2,3,3,0.
- PERIOD=0, auto → mode advances every frame. Mid-cycle write CTRL=0x9 (mode 2, auto off) → mode 2 holds indefinitely and the counter stays 0.
- Assert `rst` mid-frame after auto cycling to mode 2 → next cycle `cur_mode`=`DEFAULT_MODE`, `out_rgb`=0, and the next `frame_start` commits no change.

Source files
------------

// File: rtl/video_bar_ctrl.sv
// Frame-synchronous control registers for the bar pattern generator: shadow/active
// register pairs, optional auto-cycling of the pattern mode, band select and RGB mux.
module video_bar_ctrl #(
   parameter int         FRAME_CNT_W  = 8,
   parameter logic [1:0] DEFAULT_MODE = 2'd0,
   parameter int         H_SIZE       = 10,
   parameter int         V_SIZE       = 10,
   parameter int         V_DISPLAY    = 480
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic              wr_addr,
   input  logic [31:0]       wr_data,
   input  logic              frame_start,
   input  logic [H_SIZE-1:0] hc,
   input  logic [V_SIZE-1:0] vc,
   input  logic [11:0]       gen_rgb,
   input  logic [11:0]       in_rgb,
   output logic [1:0]        band_sel,
   output logic [11:0]       out_rgb,
   output logic [1:0]        cur_mode,
   output logic              bar_en
);

   localparam logic [V_SIZE-1:0] BAND1_Y = V_SIZE'(V_DISPLAY / 3);
   localparam logic [V_SIZE-1:0] BAND2_Y = V_SIZE'((V_DISPLAY / 3) * 2);

   logic                   sh_en, sh_auto;
   logic [1:0]             sh_mode;
   logic [FRAME_CNT_W-1:0] sh_period;
   logic                   act_en;
   logic [1:0]             act_mode;
   logic [FRAME_CNT_W-1:0] frame_cnt;
   logic [FRAME_CNT_W-1:0] eff_m1;
   logic                   pending;

   // hc is only carried for symmetry with the generator; upper write bits are reserved
   logic unused_bits;
   assign unused_bits = ^{hc, wr_data};

   // A period of 0 behaves as 1, so the terminal count is 0 in both cases
   assign eff_m1 = (sh_period == '0) ? '0 : sh_period - 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_en     <= 1'b0;
         sh_auto   <= 1'b0;
         sh_mode   <= DEFAULT_MODE;
         sh_period <= FRAME_CNT_W'(60);
         act_en    <= 1'b0;
         act_mode  <= DEFAULT_MODE;
         frame_cnt <= '0;
         pending   <= 1'b0;
      end else begin
         if (frame_start) begin
            act_en   <= sh_en;
            act_mode <= sh_mode;
            pending  <= 1'b0;
            if (pending || !sh_auto) begin
               frame_cnt <= '0;
            end else if (frame_cnt >= eff_m1) begin
               // advanced mode goes back to shadow so a PERIOD-only write keeps it
               act_mode  <= sh_mode + 2'd1;
               sh_mode   <= sh_mode + 2'd1;
               frame_cnt <= '0;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
         // Placed after the commit so a write on the frame_start cycle lands in
         // shadow and stays pending for the following frame
         if (wr_en) begin
            if (!wr_addr) begin
               sh_en   <= wr_data[0];
               sh_auto <= wr_data[1];
               sh_mode <= wr_data[3:2];
               pending <= 1'b1;
            end else begin
               sh_period <= wr_data[FRAME_CNT_W-1:0];
            end
         end
      end
   end

   always_comb begin
      band_sel = 2'd0;
      case (act_mode)
         2'd0: begin
            if (vc < BAND1_Y)      band_sel = 2'd0;
            else if (vc < BAND2_Y) band_sel = 2'd1;
            else                   band_sel = 2'd2;
         end
         2'd1:    band_sel = 2'd0;
         2'd2:    band_sel = 2'd1;
         default: band_sel = 2'd2;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) out_rgb <= '0;
      else     out_rgb <= act_en ? gen_rgb : in_rgb;
   end

   assign cur_mode = act_mode;
   assign bar_en   = act_en;

endmodule

// File: tb/tb_video_bar_ctrl.sv
// Directed bench for video_bar_ctrl: band-select table plus hand-written
// commit timing, auto-cycling and reset sequences.
module tb_video_bar_ctrl;

   logic        clk = 1'b0;
   logic        rst, wr_en, wr_addr, frame_start;
   logic [31:0] wr_data;
   logic [9:0]  hc, vc;
   logic [11:0] gen_rgb, in_rgb;
   logic [1:0]  band_sel, cur_mode;
   logic [11:0] out_rgb;
   logic        bar_en;

   int checks = 0;
   int errors = 0;

   video_bar_ctrl dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .frame_start(frame_start), .hc(hc), .vc(vc), .gen_rgb(gen_rgb), .in_rgb(in_rgb),
      .band_sel(band_sel), .out_rgb(out_rgb), .cur_mode(cur_mode), .bar_en(bar_en)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] ctrl;
      logic [9:0]  y;
      logic [1:0]  band;
      logic [1:0]  mode;
   } vec_t;
   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   initial begin
      int exp_seq[9];
      vecs[0]  = '{32'h0, 10'd0,   2'd0, 2'd0};
      vecs[1]  = '{32'h0, 10'd159, 2'd0, 2'd0};
      vecs[2]  = '{32'h0, 10'd160, 2'd1, 2'd0};
      vecs[3]  = '{32'h0, 10'd319, 2'd1, 2'd0};
      vecs[4]  = '{32'h0, 10'd320, 2'd2, 2'd0};
      vecs[5]  = '{32'h0, 10'd479, 2'd2, 2'd0};
      vecs[6]  = '{32'h4, 10'd0,   2'd0, 2'd1};
      vecs[7]  = '{32'h4, 10'd400, 2'd0, 2'd1};
      vecs[8]  = '{32'h8, 10'd0,   2'd1, 2'd2};
      vecs[9]  = '{32'h8, 10'd400, 2'd1, 2'd2};
      vecs[10] = '{32'hC, 10'd0,   2'd2, 2'd3};
      vecs[11] = '{32'hC, 10'd400, 2'd2, 2'd3};
      exp_seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

      rst = 1'b1; wr_en = 1'b0; wr_addr = 1'b0; wr_data = '0; frame_start = 1'b0;
      hc = '0; vc = '0; gen_rgb = 12'hABC; in_rgb = 12'h123;
      tick(); tick();
      rst = 1'b0;
      chk("reset bar_en", bar_en, 0);
      chk("reset cur_mode", cur_mode, 0);
      chk("reset out_rgb", out_rgb, 0);

      // No writes: passthrough of in_rgb with one cycle latency
      tick();
      chk("pass out_rgb", out_rgb, 12'h123);
      in_rgb = 12'h456;
      #1 chk("pass latency", out_rgb, 12'h123);
      tick();
      chk("pass out_rgb2", out_rgb, 12'h456);
      frame();
      chk("no write bar_en", bar_en, 0);
      chk("no write mode", cur_mode, 0);

      // Band select table
      for (int i = 0; i < 12; i++) begin
         wr(1'b0, vecs[i].ctrl);
         frame();
         vc = vecs[i].y;
         #1;
         chk($sformatf("tbl%0d mode", i), cur_mode, vecs[i].mode);
         chk($sformatf("tbl%0d band", i), band_sel, vecs[i].band);
      end
      vc = '0;

      // CTRL=0x1 mid-frame: invisible until after the next frame_start
      wr(1'b0, 32'h1);
      tick(); tick();
      chk("pre-commit bar_en", bar_en, 0);
      chk("pre-commit mode", cur_mode, 3);
      in_rgb = 12'h777; gen_rgb = 12'h5A5;
      frame();
      chk("commit bar_en", bar_en, 1);
      chk("commit mode", cur_mode, 0);
      chk("first pixel still in_rgb", out_rgb, 12'h777);
      tick();
      chk("gen_rgb selected", out_rgb, 12'h5A5);

      // CTRL write in the same cycle as frame_start waits for the next pulse
      wr_en = 1'b1; wr_addr = 1'b0; wr_data = 32'hD; frame_start = 1'b1;
      tick();
      wr_en = 1'b0; frame_start = 1'b0;
      chk("same-cycle not committed", cur_mode, 0);
      tick(); tick();
      frame();
      chk("same-cycle later commit", cur_mode, 3);
      vc = 10'd0;   #1 chk("mode3 band vc0", band_sel, 2);
      vc = 10'd200; #1 chk("mode3 band vc200", band_sel, 2);
      vc = 10'd470; #1 chk("mode3 band vc470", band_sel, 2);

      // Auto with period 2
      wr(1'b1, 32'd2);
      wr(1'b0, 32'h3);
      for (int i = 0; i < 9; i++) begin
         tick();
         frame();
         chk($sformatf("auto p2 frame%0d", i), cur_mode, exp_seq[i]);
      end

      // Period 0 acts as 1: advance every frame
      wr(1'b1, 32'd0);
      for (int i = 1; i <= 3; i++) begin
         frame();
         chk($sformatf("auto p0 frame%0d", i), cur_mode, i);
      end
      wr(1'b0, 32'h9);
      for (int i = 0; i < 4; i++) begin
         frame();
         chk($sformatf("manual hold%0d", i), cur_mode, 2);
      end
      // Re-enabling auto at period 2 must start from a cleared count
      wr(1'b1, 32'd2);
      wr(1'b0, 32'hB);
      frame(); chk("reauto commit", cur_mode, 2);
      frame(); chk("reauto hold", cur_mode, 2);
      frame(); chk("reauto advance", cur_mode, 3);

      // Reset mid-frame after cycling to mode 2
      wr(1'b1, 32'd1);
      wr(1'b0, 32'h3);
      frame(); frame(); frame();
      chk("pre-reset mode", cur_mode, 2);
      tick();
      chk("pre-reset out_rgb", out_rgb, 12'h5A5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst mode", cur_mode, 0);
      chk("rst out_rgb", out_rgb, 0);
      chk("rst bar_en", bar_en, 0);
      tick();
      frame();
      chk("post-rst frame mode", cur_mode, 0);
      chk("post-rst frame bar_en", bar_en, 0);
      frame();
      chk("post-rst frame2 mode", cur_mode, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
